// File: rtl/ca3_pkg.sv
// Shared CA3 definitions: FSM state encoding, default theta thresholds
// (also used by phi_n_neural_processor) and the saturating add used for weight updates.
// No ports; pure package.
package ca3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEARN  = 3'd1,
        ST_RECALL = 3'd2,
        ST_DONE   = 3'd3,
        ST_DECAY  = 3'd4
    } ca3_state_t;

    // Q4.14 theta thresholds: +/-0.75
    localparam int CA3_PEAK_THRESH   = 12288;
    localparam int CA3_TROUGH_THRESH = -12288;

    // a + b clipped to the signed range of a ww-bit weight
    function automatic int sat_add(input int a, input int b, input int ww);
        int hi;
        int lo;
        int sum;
        hi  = (1 << (ww - 1)) - 1;
        lo  = -hi - 1;
        sum = a + b;
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/ca3_row_update.sv
// Combinational next-row weights for LEARN and DECAY, plus the row's recall sum.
// Latency: zero (pure combinational), evaluated for whichever row the counter selects.
// Ports: i_row row index, i_w_row current row, i_pat active units -> o_learn_row, o_decay_row, o_acc.
module ca3_row_update
    import ca3_pkg::*;
#(
    parameter int N   = 6,
    parameter int WW  = 8,
    parameter int LR  = 4,
    parameter int LTD = 1
) (
    input  logic [$clog2(N)-1:0]             i_row,
    input  logic [N-1:0][WW-1:0]             i_w_row,
    input  logic [N-1:0]                     i_pat,
    output logic [N-1:0][WW-1:0]             o_learn_row,
    output logic [N-1:0][WW-1:0]             o_decay_row,
    output logic signed [WW+$clog2(N):0]     o_acc
);

    localparam int AW = WW + $clog2(N) + 1;

    logic              w_self;
    logic signed [WW-1:0] w_j;

    assign w_self = i_pat[i_row];

    always_comb begin
        o_learn_row = i_w_row;
        o_decay_row = i_w_row;
        o_acc       = '0;
        w_j         = '0;
        for (int j = 0; j < N; j++) begin
            w_j = $signed(i_w_row[j]);
            // diagonal passes through untouched (held at 0 from reset)
            if (j != int'(i_row)) begin
                if (i_pat[j] && w_self) begin
                    o_learn_row[j] = WW'(sat_add(int'(w_j), LR, WW));
                end else if (i_pat[j] ^ w_self) begin
                    o_learn_row[j] = WW'(sat_add(int'(w_j), -LTD, WW));
                end

                // step one toward zero; the sign bit picks the direction
                if (w_j[WW-1]) begin
                    o_decay_row[j] = w_j + WW'(1);
                end else if (w_j != '0) begin
                    o_decay_row[j] = w_j - WW'(1);
                end

                if (i_pat[j]) begin
                    o_acc = o_acc + AW'(w_j);
                end
            end
        end
    end

endmodule

// File: rtl/ca3_assoc_memory_param.sv
// Theta-gated CA3 autoassociative memory: Hebbian learn at peak entry, cue completion at trough entry.
// Latency: state entry 1 clk after the clk_en event; LEARN/DECAY N clks; RECALL N clks + DONE, o_out_valid in cycle N+1.
// No backpressure: entry events arriving while busy are dropped. Ports: theta/pattern/decay inputs, weight read port, status and pattern_out.
module ca3_assoc_memory_param
    import ca3_pkg::*;
#(
    parameter int WIDTH         = 18,
    parameter int N             = 6,
    parameter int WW            = 8,
    parameter int LR            = 4,
    parameter int LTD           = 1,
    parameter int PEAK_THRESH   = CA3_PEAK_THRESH,
    parameter int TROUGH_THRESH = CA3_TROUGH_THRESH,
    parameter int RECALL_THRESH = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_clk_en,
    input  logic signed [WIDTH-1:0]     i_theta_x,
    input  logic [N-1:0]                i_pattern_in,
    input  logic                        i_decay_en,
    input  logic [$clog2(N)-1:0]        i_rd_row,
    input  logic [$clog2(N)-1:0]        i_rd_col,
    output logic signed [WW-1:0]        o_rd_weight,
    output logic                        o_learning,
    output logic                        o_recalling,
    output logic                        o_busy,
    output logic [N-1:0]                o_pattern_out,
    output logic                        o_out_valid
);

    localparam int RW = $clog2(N);
    localparam int AW = WW + $clog2(N) + 1;
    localparam logic [RW-1:0]          LAST_ROW = RW'(N - 1);
    localparam logic signed [WIDTH-1:0] PEAK_T   = WIDTH'(PEAK_THRESH);
    localparam logic signed [WIDTH-1:0] TROUGH_T = WIDTH'(TROUGH_THRESH);
    localparam logic signed [AW-1:0]    RECALL_T = AW'(RECALL_THRESH);

    ca3_state_t            r_state;
    logic [RW-1:0]         r_row;
    logic [N-1:0]          r_pat_q;
    logic [N-1:0]          r_next;
    logic                  r_prev_peak;
    logic                  r_prev_trough;
    logic                  r_learning;
    logic                  r_recalling;
    logic                  r_busy;
    logic [N-1:0]          r_pattern_out;
    logic                  r_out_valid;
    logic [N-1:0][WW-1:0]  r_w [N];

    logic                  w_peak;
    logic                  w_trough;
    logic                  w_peak_entry;
    logic                  w_trough_entry;
    logic                  w_pat_nz;
    logic [N-1:0][WW-1:0]  w_row;
    logic [N-1:0][WW-1:0]  w_learn_row;
    logic [N-1:0][WW-1:0]  w_decay_row;
    logic signed [AW-1:0]  w_acc;
    logic                  w_recall_bit;
    logic [N-1:0]          w_next_full;
    logic                  w_last_row;

    assign w_peak         = (i_theta_x >= PEAK_T);
    assign w_trough       = (i_theta_x <= TROUGH_T);
    assign w_peak_entry   = i_clk_en && w_peak && !r_prev_peak;
    assign w_trough_entry = i_clk_en && w_trough && !r_prev_trough;
    assign w_pat_nz       = (i_pattern_in != '0);
    assign w_last_row     = (r_row == LAST_ROW);

    assign w_row = r_w[r_row];

    ca3_row_update #(
        .N   (N),
        .WW  (WW),
        .LR  (LR),
        .LTD (LTD)
    ) u_row_update (
        .i_row       (r_row),
        .i_w_row     (w_row),
        .i_pat       (r_pat_q),
        .o_learn_row (w_learn_row),
        .o_decay_row (w_decay_row),
        .o_acc       (w_acc)
    );

    assign w_recall_bit = r_pat_q[r_row] | (w_acc > RECALL_T);

    // completed pattern including the row being evaluated this cycle
    always_comb begin
        w_next_full        = r_next;
        w_next_full[r_row] = w_recall_bit;
    end

    // Control FSM with registered status outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_row         <= '0;
            r_pat_q       <= '0;
            r_next        <= '0;
            r_prev_peak   <= 1'b0;
            r_prev_trough <= 1'b0;
            r_learning    <= 1'b0;
            r_recalling   <= 1'b0;
            r_busy        <= 1'b0;
            r_pattern_out <= '0;
            r_out_valid   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (i_clk_en) begin
                r_prev_peak   <= w_peak;
                r_prev_trough <= w_trough;
            end

            case (r_state)
                ST_IDLE: begin
                    r_row <= '0;
                    if (w_peak_entry && w_pat_nz) begin
                        r_pat_q    <= i_pattern_in;
                        r_state    <= ST_LEARN;
                        r_learning <= 1'b1;
                        r_busy     <= 1'b1;
                    end else if (w_trough_entry && w_pat_nz) begin
                        // a nonzero cue wins over decay_en
                        r_pat_q     <= i_pattern_in;
                        r_state     <= ST_RECALL;
                        r_recalling <= 1'b1;
                        r_busy      <= 1'b1;
                    end else if (w_trough_entry && i_decay_en) begin
                        r_state <= ST_DECAY;
                        r_busy  <= 1'b1;
                    end
                end

                ST_LEARN, ST_DECAY: begin
                    if (w_last_row) begin
                        r_state    <= ST_IDLE;
                        r_learning <= 1'b0;
                        r_busy     <= 1'b0;
                        r_row      <= '0;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end

                ST_RECALL: begin
                    r_next <= w_next_full;
                    if (w_last_row) begin
                        // result is published as DONE begins so the pulse lands in cycle N+1
                        r_state       <= ST_DONE;
                        r_recalling   <= 1'b0;
                        r_pattern_out <= w_next_full;
                        r_out_valid   <= 1'b1;
                        r_row         <= '0;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_learning  <= 1'b0;
                    r_recalling <= 1'b0;
                    r_busy      <= 1'b0;
                    r_row       <= '0;
                end
            endcase
        end
    end

    // Weight matrix: one row written per cycle in LEARN or DECAY
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N; i++) begin
                r_w[i] <= '0;
            end
        end else if (r_state == ST_LEARN) begin
            r_w[r_row] <= w_learn_row;
        end else if (r_state == ST_DECAY) begin
            r_w[r_row] <= w_decay_row;
        end
    end

    // Read port: diagonal and out-of-range addresses read as 0
    always_comb begin
        o_rd_weight = '0;
        if (i_rd_row <= LAST_ROW && i_rd_col <= LAST_ROW && i_rd_row != i_rd_col) begin
            o_rd_weight = r_w[i_rd_row][i_rd_col];
        end
    end

    assign o_learning    = r_learning;
    assign o_recalling   = r_recalling;
    assign o_busy        = r_busy;
    assign o_pattern_out = r_pattern_out;
    assign o_out_valid   = r_out_valid;

endmodule

// File: tb/tb_ca3_assoc_memory_param.sv
// Bench for ca3_assoc_memory_param: directed learn/recall/decay/saturation/reset sequences.
// Recall results are checked by a monitor against a queue of expected patterns and arrival cycles.
// Weight and status values are checked directly through the read port.
module tb_ca3_assoc_memory_param;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int N      = 6;
    localparam int PEAK   = 16384;
    localparam int TROUGH = -16384;

    logic               clk = 1'b0;
    logic               rst;
    logic               clk_en;
    logic signed [17:0] theta;
    logic [5:0]         pattern_in;
    logic               decay_en;
    logic [2:0]         rd_row;
    logic [2:0]         rd_col;
    logic signed [7:0]  rd_weight;
    logic               learning;
    logic               recalling;
    logic               busy;
    logic [5:0]         pattern_out;
    logic               out_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lrn_cyc = 0;
    int rcl_cyc = 0;
    logic [5:0] exp_pat_q[$];
    int         exp_cyc_q[$];

    ca3_assoc_memory_param dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_clk_en      (clk_en),
        .i_theta_x     (theta),
        .i_pattern_in  (pattern_in),
        .i_decay_en    (decay_en),
        .i_rd_row      (rd_row),
        .i_rd_col      (rd_col),
        .o_rd_weight   (rd_weight),
        .o_learning    (learning),
        .o_recalling   (recalling),
        .o_busy        (busy),
        .o_pattern_out (pattern_out),
        .o_out_valid   (out_valid)
    );

    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every out_valid must match the oldest expected recall
    always @(negedge clk) begin
        if (learning)  lrn_cyc++;
        if (recalling) rcl_cyc++;
        if (out_valid) begin
            if (exp_pat_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid pattern_out=%b", pattern_out);
            end else begin
                chk("recall_pattern", int'(pattern_out), int'(exp_pat_q.pop_front()));
                chk("recall_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // One clk_en cycle with the given theta sample, pattern and decay enable
    task automatic strobe(input int th, input logic [5:0] p, input logic d);
        theta      = 18'(th);
        pattern_in = p;
        decay_en   = d;
        clk_en     = 1'b1;
        @(negedge clk);
        clk_en     = 1'b0;
        pattern_in = '0;
        decay_en   = 1'b0;
    endtask

    task automatic learn(input logic [5:0] p);
        strobe(0, 6'b0, 1'b0);
        strobe(PEAK, p, 1'b0);
        repeat (N + 2) @(negedge clk);
    endtask

    task automatic rd(input int r, input int c, output int v);
        rd_row = 3'(r);
        rd_col = 3'(c);
        #1;
        v = int'(rd_weight);
    endtask

    task automatic chk_w(input string name, input int r, input int c, input int exp);
        int v;
        rd(r, c, v);
        chk(name, v, exp);
    endtask

    initial begin
        int v;
        int acc;
        rst = 1'b1; clk_en = 1'b0; theta = '0; pattern_in = '0; decay_en = 1'b0;
        rd_row = '0; rd_col = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_learning", int'(learning), 0);
        chk("rst_recalling", int'(recalling), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_pattern_out", int'(pattern_out), 0);
        chk_w("rst_w13", 1, 3, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single learn of units 1,3,5
        lrn_cyc = 0;
        learn(6'b101010);
        chk("learn_cycles", lrn_cyc, 6);
        chk("learn_idle", int'(busy), 0);
        chk_w("w13", 1, 3, 4);
        chk_w("w31", 3, 1, 4);
        chk_w("w01", 0, 1, -1);
        chk_w("w10", 1, 0, -1);
        chk_w("w02", 0, 2, 0);
        chk_w("w33_diag", 3, 3, 0);
        acc = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                rd(r, c, v);
                acc += (v < 0) ? -v : v;
            end
        end
        chk("sum_abs_dw", acc, 42);

        // Decay at trough entry with zero pattern
        strobe(0, 6'b0, 1'b0);
        strobe(TROUGH, 6'b0, 1'b1);
        repeat (N + 2) @(negedge clk);
        chk_w("decay_w13", 1, 3, 3);
        chk_w("decay_w01", 0, 1, 0);
        chk_w("decay_w35", 3, 5, 3);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_w("rst2_w13", 1, 3, 0);

        // Five learns then recall from cue on unit 5 (decay_en high too: recall wins)
        for (int k = 0; k < 5; k++) learn(6'b101010);
        chk_w("w35_x5", 3, 5, 20);
        chk_w("w53_x5", 5, 3, 20);
        chk_w("w05_x5", 0, 5, -5);
        strobe(0, 6'b0, 1'b0);
        exp_pat_q.push_back(6'b101010);
        exp_cyc_q.push_back(cyc + N + 1);
        rcl_cyc = 0;
        strobe(TROUGH, 6'b100000, 1'b1);
        repeat (N + 3) @(negedge clk);
        chk("recall_cycles", rcl_cyc, 6);
        chk_w("recall_nodecay_w35", 3, 5, 20);
        chk_w("oob_row", 6, 1, 0);
        chk_w("oob_col", 1, 7, 0);

        // Theta held in peak: only the first clk_en is an entry
        lrn_cyc = 0;
        strobe(0, 6'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            strobe(PEAK, 6'b000011, 1'b0);
            repeat (8) @(negedge clk);
        end
        chk("reentry_learn_cycles", lrn_cyc, 6);
        chk_w("reentry_w01", 0, 1, -1);

        // Trough entry during LEARN is dropped (no recall, no decay)
        strobe(0, 6'b0, 1'b0);
        strobe(PEAK, 6'b000011, 1'b0);
        strobe(TROUGH, 6'b000001, 1'b1);
        repeat (8) @(negedge clk);
        chk_w("busy_w01", 0, 1, 3);
        chk_w("busy_w35", 3, 5, 20);
        chk("busy_no_pending", exp_pat_q.size(), 0);

        // Reset during row 3 of LEARN
        strobe(0, 6'b0, 1'b0);
        strobe(PEAK, 6'b111111, 1'b0);
        repeat (3) @(negedge clk);
        chk("pre_rst_learning", int'(learning), 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_learning", int'(learning), 0);
        chk("midrst_pattern_out", int'(pattern_out), 0);
        acc = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                rd(r, c, v);
                if (v != 0) acc++;
            end
        end
        chk("midrst_nonzero_weights", acc, 0);
        @(negedge clk);
        rst = 1'b0;

        // Saturation: 40 learns of units 4,5
        for (int k = 0; k < 40; k++) learn(6'b110000);
        chk_w("sat_w54", 5, 4, 127);
        chk_w("sat_w45", 4, 5, 127);
        chk_w("sat_w05", 0, 5, -40);
        chk_w("sat_w34", 3, 4, -40);
        chk_w("sat_w01", 0, 1, 0);

        repeat (4) @(negedge clk);
        chk("final_no_pending", exp_pat_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ca3_assoc_memory_param.md
# ca3_assoc_memory_param

Parametrised CA3 autoassociative memory: an N-unit Hebbian weight matrix that is gated by theta phase. It learns the presented pattern once per theta-peak entry and completes a cue once per theta-trough entry. It is the generalised successor to the fixed 6-unit CA3 memory inside `phi_n_neural_processor`, and sits between the thalamic/cortical pattern encoder and the hippocampal output. New capabilities over its predecessor: configurable unit count and weight width, separate potentiation and depression rates, optional weight decay, and a weight read port.

## Interface
- `WIDTH`, 18: theta sample width (signed Q4.14).
- `N`, 6: number of units; minimum 2.
- `WW`, 8: signed weight width.
- `LR`, 4: potentiation step.
- `LTD`, 1: depression step.
- `PEAK_THRESH`, 12288: theta peak threshold.
- `TROUGH_THRESH`, -12288: theta trough threshold.
- `RECALL_THRESH`, 0: activation threshold for completing a unit.
- `clk`  in  1  system clock (125 MHz).
- `rst`  in  1  reset; asynchronous, active-high.
- `clk_en`  in  1  4 kHz update strobe, one cycle wide.
- `theta_x`  in  WIDTH  signed theta oscillator sample.
- `pattern_in`  in  N  learn pattern, or recall cue; bit i is unit i.
- `decay_en`  in  1  enables weight decay at trough entry.
- `rd_row`, `rd_col`  in  clog2(N) each  weight read address.
- `rd_weight`  out  WW  combinational `w[rd_row][rd_col]`.
- `learning`  out  1  high while the LEARN state is active.
- `recalling`  out  1  high while the RECALL state is active.
- `busy`  out  1  state != IDLE.
- `pattern_out`  out  N  last completed pattern (registered).
- `out_valid`  out  1  one-cycle pulse when `pattern_out` updates.

## Operation
- Regions are sampled only on `clk_en`:
  - peak = `theta_x >= PEAK_THRESH`;
  - trough = `theta_x <= TROUGH_THRESH`.
  - Registered flags hold the previous sample's region.
- Entry events, evaluated on `clk_en`:
  - peak entry = peak and not previous peak;
  - trough entry likewise.
  - Peak and trough are mutually exclusive, so the two entries cannot coincide.
- Events are accepted only in IDLE. Events arriving while busy are dropped.
- IDLE transitions:
  - peak entry with `pattern_in != 0`: latch `pattern_in` into `pat_q`, go to LEARN;
  - trough entry with `pattern_in != 0`: latch `pat_q`, go to RECALL;
  - trough entry with `pattern_in == 0` and `decay_en`: go to DECAY.
  - If a trough entry carries a nonzero cue and `decay_en` is also high, RECALL has priority and decay is skipped for that cycle.
- LEARN: processes row r = 0..N-1, one row per `clk` cycle. For each j != i:
  - both units active: w += LR;
  - exactly one active: w -= LTD;
  - neither active: unchanged.
  - Results saturate to [-2^(WW-1), 2^(WW-1)-1].
  - After row N-1, go to IDLE.
- RECALL: one row per cycle. `acc_i = sum over j != i with pat_q[j] of w[i][j]`, computed with a signed accumulator of width WW+clog2(N)+1.
  - Then `next[i] = pat_q[i] | (acc_i > RECALL_THRESH)`.
  - After row N-1, go to DONE.
- DONE: `pattern_out <= next`, pulse `out_valid`, go to IDLE.
- DECAY: one row per cycle; every nonzero weight moves 1 toward 0. Then go to IDLE.
- The diagonal is always 0 and is never written.
- Reading `rd_row == rd_col`, or an out-of-range address, returns 0.

## Timing
- Event detect to state entry: 1 clk after the `clk_en` cycle.
- LEARN and DECAY last N cycles.
- RECALL lasts N cycles, plus 1 DONE cycle. `out_valid` is asserted N+1 clks after the event cycle.
- `learning` and `recalling` are high for exactly N cycles per event.
- Row writes take effect on the clock edge ending that row's cycle.
- Reset values: all weights 0, `pattern_out` 0, `out_valid`/`learning`/`recalling`/`busy` 0, region flags 0, state IDLE.
- Reset asserted mid-operation aborts immediately and clears all weights, including partially written rows.
- After reset, if the first `clk_en` sample is already in a region, it counts as an entry.

## Structure
- A shared package `ca3_pkg` holds:
  - the state enum {IDLE, LEARN, RECALL, DONE, DECAY};
  - the saturating-add function;
  - the default theta thresholds, also used by `phi_n_neural_processor`.
- One sub-module, `ca3_row_update`: combinational next-row weights for LEARN and DECAY plus the row's recall sum. It is instanced once and muxed by the row counter.

## Test plan
- **Single learn**:
  - Stimulus: N=6, LR=4, LTD=1; one peak entry with `pattern_in=101010`.
  - Required: `learning` high for 6 cycles; `w[1][3]=4`; `w[0][1]=-1`; `w[0][2]=0`; sum of |Δw| = 42.
- **Five learns, then recall**:
  - Stimulus: five learns of 101010; trough entry with cue 100000.
  - Required: `w[3][5]=20`, `w[0][5]=-5`; `pattern_out=101010`; `out_valid` 7 clks after the event.
- **Saturation**:
  - Stimulus: 40 learns of 110000.
  - Required: `w[5][4]=127`; `w[0][5]=-40`; no wrap-around.
- **Decay**:
  - Stimulus: after one learn of 101010, trough entry with `pattern_in=0` and `decay_en=1`.
  - Required: `w[1][3]=3`, `w[0][1]=0`.
- **Event while busy / re-entry**:
  - Stimulus: hold theta in the peak region across several `clk_en`; separately, force a trough entry during LEARN.
  - Required: exactly one learn per peak entry; the trough event is dropped.
- **Reset mid-LEARN**:
  - Stimulus: assert `rst` at row 3.
  - Required: all outputs and weights read 0 immediately; state IDLE.
